// File: rtl/game_pkg.sv
// Shared geometry and encodings for the game sequencer and the renderer.
// Holds playfield/ceiling/paddle/floor coordinates, the derived ball and
// paddle position limits, the GAME_STATE encoding and the per-frame
// update-phase encoding.
package game_pkg;

  // Playfield spans X 8..791; FIELD_X_END is the first column past it.
  localparam int FIELD_X_MIN = 8;
  localparam int FIELD_X_END = 792;
  localparam int CEILING_Y   = 80;   // bottom edge of the ceiling band
  localparam int PADDLE_Y    = 584;  // paddle top row
  localparam int SCREEN_Y    = 600;  // screen bottom

  localparam int PADDLE_LEN_DEFAULT = 60;
  localparam int BALL_SIZE_DEFAULT  = 8;

  function automatic int ball_x_max(input int ball_size);
    return FIELD_X_END - ball_size;
  endfunction

  function automatic int paddle_x_max(input int paddle_len);
    return FIELD_X_END - paddle_len;
  endfunction

  function automatic int ball_rest_y(input int ball_size);
    return PADDLE_Y - ball_size;
  endfunction

  localparam int BALL_X_MAX   = ball_x_max(BALL_SIZE_DEFAULT);     // 784
  localparam int PADDLE_X_MAX = paddle_x_max(PADDLE_LEN_DEFAULT);  // 732
  localparam int BALL_REST_Y  = ball_rest_y(BALL_SIZE_DEFAULT);    // 576

  typedef enum logic [1:0] {
    GS_SERVE = 2'd0,
    GS_PLAY  = 2'd1,
    GS_LOST  = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_PADDLE = 2'd1,
    PH_BALL   = 2'd2,
    PH_COMMIT = 2'd3
  } phase_t;

endpackage

// File: rtl/ball_step_unit.sv
// Combinational one-frame ball advance.
// Inputs : ball_x/ball_y (top-left), dx/dy (signed velocity), paddle_x.
// Outputs: next_x/next_y, next_dx/next_dy, and event flags
//          hit_wall, hit_ceiling, hit_paddle, hit_floor.
// X and Y reflections are independent; a paddle catch suppresses the floor.
module ball_step_unit
  import game_pkg::*;
#(
  parameter int BALL_SIZE_PIXEL     = 8,
  parameter int PADDLE_LENGTH_PIXEL = 60,
  parameter int BALL_SPEED          = 2
) (
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic signed [10:0] dx,
  input  logic signed [10:0] dy,
  input  logic [9:0]        paddle_x,
  output logic [9:0]        next_x,
  output logic [9:0]        next_y,
  output logic signed [10:0] next_dx,
  output logic signed [10:0] next_dy,
  output logic              hit_wall,
  output logic              hit_ceiling,
  output logic              hit_paddle,
  output logic              hit_floor
);

  localparam int X_MAX  = ball_x_max(BALL_SIZE_PIXEL);
  localparam int REST_Y = ball_rest_y(BALL_SIZE_PIXEL);
  localparam logic signed [10:0] SPD_POS = 11'(BALL_SPEED);
  localparam logic signed [10:0] SPD_NEG = 11'(-BALL_SPEED);

  int cand_x;
  int cand_y;

  always_comb begin
    cand_x      = int'(ball_x) + int'(dx);
    cand_y      = int'(ball_y) + int'(dy);
    next_dx     = dx;
    next_dy     = dy;
    hit_wall    = 1'b0;
    hit_ceiling = 1'b0;
    hit_paddle  = 1'b0;
    hit_floor   = 1'b0;

    if (cand_x < FIELD_X_MIN) begin
      cand_x   = FIELD_X_MIN;
      next_dx  = SPD_POS;
      hit_wall = 1'b1;
    end else if (cand_x > X_MAX) begin
      cand_x   = X_MAX;
      next_dx  = SPD_NEG;
      hit_wall = 1'b1;
    end

    if (cand_y < CEILING_Y) begin
      cand_y      = CEILING_Y;
      next_dy     = SPD_POS;
      hit_ceiling = 1'b1;
    end

    // Catch only when descending and crossing the resting row this frame,
    // with overlap measured at the (clamped) new X.
    if (dy > 11'sd0 && int'(ball_y) <= REST_Y && cand_y >= REST_Y &&
        cand_x + BALL_SIZE_PIXEL > int'(paddle_x) &&
        cand_x < int'(paddle_x) + PADDLE_LENGTH_PIXEL) begin
      cand_y     = REST_Y;
      next_dy    = SPD_NEG;
      hit_paddle = 1'b1;
    end else if (cand_y >= SCREEN_Y) begin
      hit_floor = 1'b1;
    end

    next_x = 10'(cand_x);
    next_y = 10'(cand_y);
  end

endmodule

// File: rtl/game_logic_controller.sv
// Per-frame game sequencer feeding the renderer.
// Inputs : CLK, RESET (sync, active-high), FRAME_DONE (vblank pulse),
//          BTN_LEFT / BTN_RIGHT / BTN_START (levels, sampled with FRAME_DONE).
// Outputs: PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, LIVES, GAME_STATE,
//          UPDATE_DONE (one-cycle pulse in the COMMIT cycle).
// Each frame runs IDLE -> PADDLE -> BALL -> COMMIT; every visible output
// changes together on entry to COMMIT, 3 cycles after FRAME_DONE.
module game_logic_controller
  import game_pkg::*;
#(
  parameter int PADDLE_LENGTH_PIXEL = 60,
  parameter int BALL_SIZE_PIXEL     = 8,
  parameter int PADDLE_SPEED        = 4,
  parameter int BALL_SPEED          = 2,
  parameter int START_LIVES         = 3,
  parameter int LOST_FRAMES         = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_DONE,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_START,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic [9:0] BALL_X_PIXEL,
  output logic [9:0] BALL_Y_PIXEL,
  output logic [1:0] LIVES,
  output logic [1:0] GAME_STATE,
  output logic       UPDATE_DONE
);

  localparam int PAD_X_MAX   = paddle_x_max(PADDLE_LENGTH_PIXEL);
  localparam int REST_Y      = ball_rest_y(BALL_SIZE_PIXEL);
  localparam int BALL_OFFSET = (PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2;
  localparam int PAD_X_RESET = (FIELD_X_MIN + FIELD_X_END - PADDLE_LENGTH_PIXEL) / 2;
  localparam int CW          = $clog2(LOST_FRAMES + 1);
  localparam logic signed [10:0] SPD_POS = 11'(BALL_SPEED);
  localparam logic signed [10:0] SPD_NEG = 11'(-BALL_SPEED);

  phase_t      phase, phase_next;
  game_state_t state, state_next;

  logic              btn_l, btn_r, btn_s;
  logic [9:0]        paddle_work, paddle_move;
  logic signed [10:0] dx, dy, dx_next, dy_next;
  logic [9:0]        bx_next, by_next;
  logic [1:0]        lives_next;
  logic [CW-1:0]     cnt, cnt_next;

  logic [9:0]        step_x, step_y;
  logic signed [10:0] step_dx, step_dy;
  logic              hit_wall, hit_ceiling, hit_paddle, hit_floor;
  logic              unused_hits;

  assign unused_hits = &{1'b0, hit_wall, hit_ceiling, hit_paddle};
  assign GAME_STATE  = state;

  ball_step_unit #(
    .BALL_SIZE_PIXEL    (BALL_SIZE_PIXEL),
    .PADDLE_LENGTH_PIXEL(PADDLE_LENGTH_PIXEL),
    .BALL_SPEED         (BALL_SPEED)
  ) u_step (
    .ball_x     (BALL_X_PIXEL),
    .ball_y     (BALL_Y_PIXEL),
    .dx         (dx),
    .dy         (dy),
    .paddle_x   (paddle_work),
    .next_x     (step_x),
    .next_y     (step_y),
    .next_dx    (step_dx),
    .next_dy    (step_dy),
    .hit_wall   (hit_wall),
    .hit_ceiling(hit_ceiling),
    .hit_paddle (hit_paddle),
    .hit_floor  (hit_floor)
  );

  // Update-phase sequencer
  always_ff @(posedge CLK) begin
    if (RESET) phase <= PH_IDLE;
    else       phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      PH_IDLE:   if (FRAME_DONE) phase_next = PH_PADDLE;
      PH_PADDLE: phase_next = PH_BALL;
      PH_BALL:   phase_next = PH_COMMIT;
      PH_COMMIT: phase_next = PH_IDLE;
      default:   phase_next = PH_IDLE;
    endcase
  end

  // Paddle move, saturated in int range so no 10-bit wrap at the edges
  always_comb begin
    paddle_move = PADDLE_X_PIXEL;
    if (state != GS_OVER) begin
      if (btn_l && !btn_r) begin
        if (int'(PADDLE_X_PIXEL) - PADDLE_SPEED < FIELD_X_MIN)
          paddle_move = 10'(FIELD_X_MIN);
        else
          paddle_move = PADDLE_X_PIXEL - 10'(PADDLE_SPEED);
      end else if (btn_r && !btn_l) begin
        if (int'(PADDLE_X_PIXEL) + PADDLE_SPEED > PAD_X_MAX)
          paddle_move = 10'(PAD_X_MAX);
        else
          paddle_move = PADDLE_X_PIXEL + 10'(PADDLE_SPEED);
      end
    end
  end

  // Game FSM next-state and committed values, evaluated in the BALL phase
  always_comb begin
    state_next = state;
    lives_next = LIVES;
    cnt_next   = cnt;
    bx_next    = BALL_X_PIXEL;
    by_next    = BALL_Y_PIXEL;
    dx_next    = dx;
    dy_next    = dy;
    case (state)
      GS_SERVE: begin
        bx_next = paddle_work + 10'(BALL_OFFSET);
        by_next = 10'(REST_Y);
        if (btn_s) begin
          state_next = GS_PLAY;
          dx_next    = SPD_POS;
          dy_next    = SPD_NEG;
        end
      end
      GS_PLAY: begin
        bx_next = step_x;
        by_next = step_y;
        dx_next = step_dx;
        dy_next = step_dy;
        if (hit_floor) begin
          lives_next = LIVES - 2'd1;
          cnt_next   = '0;
          state_next = (LIVES == 2'd1) ? GS_OVER : GS_LOST;
        end
      end
      GS_LOST: begin
        cnt_next = cnt + CW'(1);
        if (cnt_next >= CW'(LOST_FRAMES - 1)) begin
          state_next = GS_SERVE;
          bx_next    = paddle_work + 10'(BALL_OFFSET);
          by_next    = 10'(REST_Y);
        end
      end
      GS_OVER: begin
        if (btn_s) begin
          lives_next = 2'(START_LIVES);
          state_next = GS_SERVE;
          bx_next    = paddle_work + 10'(BALL_OFFSET);
          by_next    = 10'(REST_Y);
        end
      end
      default: state_next = GS_SERVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= GS_SERVE;
      PADDLE_X_PIXEL <= 10'(PAD_X_RESET);
      paddle_work    <= 10'(PAD_X_RESET);
      BALL_X_PIXEL   <= 10'(PAD_X_RESET + BALL_OFFSET);
      BALL_Y_PIXEL   <= 10'(REST_Y);
      LIVES          <= 2'(START_LIVES);
      UPDATE_DONE    <= 1'b0;
      dx             <= SPD_POS;
      dy             <= SPD_NEG;
      cnt            <= '0;
      btn_l          <= 1'b0;
      btn_r          <= 1'b0;
      btn_s          <= 1'b0;
    end else begin
      UPDATE_DONE <= (phase == PH_BALL);
      if (phase == PH_IDLE && FRAME_DONE) begin
        btn_l <= BTN_LEFT;
        btn_r <= BTN_RIGHT;
        btn_s <= BTN_START;
      end
      if (phase == PH_PADDLE) paddle_work <= paddle_move;
      if (phase == PH_BALL) begin
        PADDLE_X_PIXEL <= paddle_work;
        BALL_X_PIXEL   <= bx_next;
        BALL_Y_PIXEL   <= by_next;
        dx             <= dx_next;
        dy             <= dy_next;
        LIVES          <= lives_next;
        cnt            <= cnt_next;
        state          <= state_next;
      end
    end
  end

endmodule

// File: tb/tb_game_logic_controller.sv
module tb_game_logic_controller;

  logic CLK = 1'b0;
  logic RESET, FRAME_DONE, BTN_LEFT, BTN_RIGHT, BTN_START;
  logic [9:0] PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
  logic [1:0] LIVES, GAME_STATE;
  logic UPDATE_DONE;

  always #5 CLK = ~CLK;

  game_logic_controller #(
    .PADDLE_LENGTH_PIXEL(60),
    .BALL_SIZE_PIXEL    (8),
    .PADDLE_SPEED       (4),
    .BALL_SPEED         (2),
    .START_LIVES        (3),
    .LOST_FRAMES        (60)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .FRAME_DONE    (FRAME_DONE),
    .BTN_LEFT      (BTN_LEFT),
    .BTN_RIGHT     (BTN_RIGHT),
    .BTN_START     (BTN_START),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL),
    .BALL_X_PIXEL  (BALL_X_PIXEL),
    .BALL_Y_PIXEL  (BALL_Y_PIXEL),
    .LIVES         (LIVES),
    .GAME_STATE    (GAME_STATE),
    .UPDATE_DONE   (UPDATE_DONE)
  );

  typedef struct {
    int px;
    int bx;
    int by;
    int lives;
    int state;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference game model, one call per frame
  int m_px, m_bx, m_by, m_dx, m_dy, m_lives, m_state, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_px = 370; m_bx = 396; m_by = 576;
    m_dx = 2; m_dy = -2; m_lives = 3; m_state = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit s);
    int nx, ny, ody;
    bit hit;
    if (m_state != 3) begin
      if (l && !r)      m_px = (m_px - 4 < 8) ? 8 : m_px - 4;
      else if (r && !l) m_px = (m_px + 4 > 732) ? 732 : m_px + 4;
    end
    case (m_state)
      0: begin
        m_bx = m_px + 26; m_by = 576;
        if (s) begin m_state = 1; m_dx = 2; m_dy = -2; end
      end
      1: begin
        ody = m_dy;
        nx = m_bx + m_dx;
        ny = m_by + m_dy;
        if (nx < 8)        begin nx = 8;   m_dx = 2;  end
        else if (nx > 784) begin nx = 784; m_dx = -2; end
        if (ny < 80)       begin ny = 80;  m_dy = 2;  end
        hit = (ody > 0) && (m_by <= 576) && (ny >= 576) && (nx + 8 > m_px) && (nx < m_px + 60);
        if (hit) begin
          ny = 576; m_dy = -2;
        end else if (ny >= 600) begin
          m_lives = m_lives - 1;
          m_cnt = 0;
          m_state = (m_lives == 0) ? 3 : 2;
        end
        m_bx = nx; m_by = ny;
      end
      2: begin
        m_cnt++;
        if (m_cnt == 59) begin m_state = 0; m_bx = m_px + 26; m_by = 576; end
      end
      default: begin
        if (s) begin m_lives = 3; m_state = 0; m_bx = m_px + 26; m_by = 576; end
      end
    endcase
  endtask

  // One frame: model predicts, scoreboard holds the prediction until the
  // DUT signals UPDATE_DONE, then the prediction is popped and compared.
  task automatic frame(input bit l, input bit r, input bit s, input bit long_pulse);
    exp_t e;
    int lat;
    bit seen, extra;
    model_step(l, r, s);
    e = '{m_px, m_bx, m_by, m_lives, m_state};
    sb.push_back(e);
    @(negedge CLK);
    FRAME_DONE = 1'b1; BTN_LEFT = l; BTN_RIGHT = r; BTN_START = s;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (!(long_pulse && lat == 1)) FRAME_DONE = 1'b0;
      BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_START = 1'b0;
      if (UPDATE_DONE === 1'b1) seen = 1'b1;
    end
    FRAME_DONE = 1'b0;
    check("latency", lat, 3);
    e = sb.pop_front();
    check("paddle_x", PADDLE_X_PIXEL, e.px);
    check("ball_x", BALL_X_PIXEL, e.bx);
    check("ball_y", BALL_Y_PIXEL, e.by);
    check("lives", LIVES, e.lives);
    check("state", GAME_STATE, e.state);
    @(negedge CLK);
    check("done_one_cycle", UPDATE_DONE, 1'b0);
    if (long_pulse) begin
      extra = 1'b0;
      repeat (4) begin
        @(negedge CLK);
        if (UPDATE_DONE !== 1'b0) extra = 1'b1;
      end
      check("busy_frame_ignored", extra, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_px"}, PADDLE_X_PIXEL, 370);
    check({tag, "_bx"}, BALL_X_PIXEL, 396);
    check({tag, "_by"}, BALL_Y_PIXEL, 576);
    check({tag, "_lives"}, LIVES, 3);
    check({tag, "_state"}, GAME_STATE, 0);
    check({tag, "_done"}, UPDATE_DONE, 1'b0);
  endtask

  // Drive to the playfield half opposite the ball so it is never caught.
  task automatic lose_current_ball();
    int n;
    n = 0;
    while (m_state == 1 && n < 2000) begin
      if (m_bx < 400) frame(1'b0, 1'b1, 1'b0, 1'b0);
      else            frame(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $error("FAIL lose_bound observed=%0d expected<2000", n);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_px, snap_bx, snap_by, n;
    bit seen;
    RESET = 1'b1; FRAME_DONE = 1'b0;
    BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_reset_values("reset");
    model_reset();

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_frame_px", PADDLE_X_PIXEL, 370);
    check("idle_frame_bx", BALL_X_PIXEL, 396);

    repeat (100) frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("left_limit_px", PADDLE_X_PIXEL, 8);
    check("serve_track_bx", BALL_X_PIXEL, 34);

    frame(1'b1, 1'b1, 1'b0, 1'b1);

    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("serve_to_play", GAME_STATE, 1);
    check("serve_no_move_bx", BALL_X_PIXEL, 34);

    repeat (248) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("rise_bx", BALL_X_PIXEL, 530);
    check("rise_by", BALL_Y_PIXEL, 80);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("ceiling_by", BALL_Y_PIXEL, 80);
    check("ceiling_bx", BALL_X_PIXEL, 532);
    repeat (127) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("right_wall_bx", BALL_X_PIXEL, 784);
    check("right_wall_by", BALL_Y_PIXEL, 334);
    repeat (132) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("fall_by", BALL_Y_PIXEL, 598);
    check("fall_bx", BALL_X_PIXEL, 520);
    check("fall_state", GAME_STATE, 1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("miss_lives", LIVES, 2);
    check("miss_state", GAME_STATE, 2);
    repeat (58) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("lost_hold_state", GAME_STATE, 2);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("lost_end_state", GAME_STATE, 0);
    check("lost_end_bx", BALL_X_PIXEL, 34);
    check("lost_end_by", BALL_Y_PIXEL, 576);

    // Rally: paddle tracks the ball, with occasional random button frames
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i % 7 == 3)
        frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      else if (m_px + 26 < m_bx - 2) frame(1'b0, 1'b1, 1'b0, 1'b0);
      else if (m_px + 26 > m_bx + 2) frame(1'b1, 1'b0, 1'b0, 1'b0);
      else                           frame(1'b0, 1'b0, 1'b0, 1'b0);
    end

    n = 0;
    while (m_state != 3 && n < 8) begin
      if (m_state == 0)      frame(1'b0, 1'b0, 1'b1, 1'b0);
      else if (m_state == 1) lose_current_ball();
      else                   repeat (59) frame(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("over_state", GAME_STATE, 3);
    check("over_lives", LIVES, 0);

    snap_px = m_px; snap_bx = m_bx; snap_by = m_by;
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("over_frozen_px", PADDLE_X_PIXEL, snap_px);
    check("over_frozen_bx", BALL_X_PIXEL, snap_bx);
    check("over_frozen_by", BALL_Y_PIXEL, snap_by);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_lives", LIVES, 3);
    check("restart_state", GAME_STATE, 0);
    check("restart_bx", BALL_X_PIXEL, snap_px + 26);

    // Reset one cycle after FRAME_DONE: the sequence must be abandoned
    @(negedge CLK);
    FRAME_DONE = 1'b1; BTN_RIGHT = 1'b1;
    @(negedge CLK);
    FRAME_DONE = 1'b0; BTN_RIGHT = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (UPDATE_DONE !== 1'b0) seen = 1'b1;
    end
    check("midseq_no_done", seen, 1'b0);
    check_reset_values("midseq");
    model_reset();
    frame(1'b0, 1'b1, 1'b0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_logic_controller.md
Name: game_logic_controller

Overview:
Per-frame game sequencer driving the paddle/ball inputs of the game renderer. On each renderer frame-done pulse it samples the player buttons, moves the paddle, advances the ball, and resolves wall, ceiling, paddle and floor events. It also tracks lives and game phase. All outputs change once per frame, during vertical blanking, so the renderer never draws a half-updated frame.

Parameters:
PADDLE_LENGTH_PIXEL, 60, paddle width in px; must match renderer
BALL_SIZE_PIXEL, 8, ball edge in px; must match renderer
PADDLE_SPEED, 4, paddle px moved per frame per held button
BALL_SPEED, 2, ball px per frame per axis
START_LIVES, 3, lives at reset and at restart
LOST_FRAMES, 60, pause frames after a lost ball

Ports:
CLK  in  1  system/pixel clock
RESET  in  1  synchronous, active-high reset
FRAME_DONE  in  1  one-cycle pulse from renderer at start of vertical blank
BTN_LEFT  in  1  level, move paddle left
BTN_RIGHT  in  1  level, move paddle right
BTN_START  in  1  level, serve/restart
PADDLE_X_PIXEL  out  10  paddle left edge
BALL_X_PIXEL  out  10  ball left edge
BALL_Y_PIXEL  out  10  ball top edge
LIVES  out  2  remaining lives
GAME_STATE  out  2  SERVE=0, PLAY=1, LOST=2, OVER=3
UPDATE_DONE  out  1  one-cycle pulse when outputs committed

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET).
- Geometry constants: playfield X 8..791; ceiling bottom edge at Y 80; paddle top at Y 584; screen bottom at Y 600.
- Derived limits: ball X range 8..784; paddle X range 8..732; ball resting Y on paddle 576.
- Reset values:
  - PADDLE_X = 370.
  - BALL_X = 396 (paddle X + 26); BALL_Y = 576.
  - LIVES = START_LIVES; GAME_STATE = SERVE; UPDATE_DONE = 0.
  - Velocity dx = +BALL_SPEED, dy = -BALL_SPEED; lost-frame counter = 0.
- Update sequencer phases: IDLE -> PADDLE -> BALL -> COMMIT -> IDLE.
  - FRAME_DONE in IDLE starts the sequence.
  - Buttons are sampled in the FRAME_DONE cycle.
  - Outputs and GAME_STATE update together in COMMIT, exactly 3 cycles after FRAME_DONE.
  - UPDATE_DONE is high in the COMMIT cycle only.
  - FRAME_DONE received outside IDLE is ignored.
- Paddle update (all states except OVER):
  - Left only: x = max(8, x - PADDLE_SPEED).
  - Right only: x = min(732, x + PADDLE_SPEED).
  - Both or neither: no move.
  - Saturation is computed without 10-bit wrap.
- The ball phase uses the new paddle X.
- SERVE:
  - Ball tracks the paddle: X = paddle X + 26, Y = 576.
  - If BTN_START is sampled high, go to PLAY with dx = +BALL_SPEED, dy = -BALL_SPEED. The ball does not move this frame.
- PLAY: candidate nx = x + dx, ny = y + dy, using signed 11-bit arithmetic.
  - nx < 8: nx = 8, dx = +BALL_SPEED.
  - nx > 784: nx = 784, dx = -BALL_SPEED.
  - ny < 80: ny = 80, dy = +BALL_SPEED.
  - Paddle hit: requires dy > 0, y <= 576 <= ny, and horizontal overlap (nx + 8 > paddle X and nx < paddle X + 60). Then ny = 576, dy = -BALL_SPEED; dx is unchanged.
  - Miss: if ny >= 600, LIVES decrements. If LIVES was 1, go to OVER (LIVES = 0); otherwise go to LOST and clear the counter.
  - The X and Y reflections are independent; a corner hit reflects both in the same frame.
  - The paddle check takes priority over the floor check.
- LOST:
  - Ball is held at its last position.
  - The counter increments each frame.
  - When the counter reaches LOST_FRAMES - 1, go to SERVE. The ball snaps to the paddle in that same COMMIT.
- OVER:
  - Paddle and ball are frozen.
  - If BTN_START is sampled high: LIVES = START_LIVES, go to SERVE, and the ball snaps to the paddle.
- RESET has priority over everything, including a sequence in progress. Any partially computed values are discarded and the reset values are restored on the next edge.

Decomposition:
- Shared package game_pkg holds:
  - geometry constants (wall, ceiling, paddle and floor coordinates; paddle/ball limits);
  - the GAME_STATE encoding;
  - the update-phase encoding.
- The renderer is to use the same geometry constants.
- One combinational sub-module, ball_step_unit.
  - Inputs: ball position, velocity, paddle X.
  - Outputs: next position, next velocity, hit flags (wall, ceiling, paddle, floor).
- The top level holds the sequencer, game FSM, lives and counter.

Test Plan:
- Reset, then one FRAME_DONE with no buttons -> PADDLE_X = 370, BALL = (396, 576), LIVES = 3, GAME_STATE = 0, UPDATE_DONE 3 cycles after the pulse.
- Hold BTN_LEFT for 100 frames from reset -> paddle reaches 8 and stays at 8; in SERVE, BALL_X = 34.
- BTN_START, then ball at (783, 200) moving (+2, -2) -> next frame (784, 198) with dx = -2; ball at (8, 81) moving (-2, -2) -> (8, 80), both dx and dy become +2.
- Ball at (400, 575) moving (+2, +2), paddle X = 380 -> (402, 576), dy = -2. Same case with paddle X = 8 -> no bounce; the ball passes 600, LIVES 3 -> 2, GAME_STATE = LOST. After 60 frames -> SERVE, ball on paddle.
- Lose a third ball -> GAME_STATE = OVER, LIVES = 0, positions frozen even with buttons held. BTN_START -> LIVES = 3, SERVE.
- Assert RESET one cycle after FRAME_DONE, mid-sequence -> no UPDATE_DONE pulse; all outputs at reset values.
